// File: rtl/entry_table_pkg.sv
// entry_table_pkg: shared sizes, read FSM states and one-hot decode for the entry table controller
package entry_table_pkg;
  localparam int NUM_ENTRIES = 32;
  localparam int IDX_W = 5;
  localparam int A_W = 5;
  localparam int B_W = 16;
  typedef enum logic [1:0] {IDLE, DRIVE, RESP} rd_state_t;
  function automatic logic [NUM_ENTRIES-1:0] onehot(input logic [IDX_W-1:0] i);
    return {{(NUM_ENTRIES-1){1'b0}}, 1'b1} << i;
  endfunction
endpackage

// File: rtl/lowest_free_enc.sv
// lowest_free_enc: index of the lowest clear bit in the valid vector plus an any-free flag
module lowest_free_enc
  import entry_table_pkg::*;
(
  input  logic [NUM_ENTRIES-1:0] valid,
  output logic [IDX_W-1:0]       idx,
  output logic                   any_free
);
  always_comb begin
    idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--)
      if (!valid[i]) idx = IDX_W'(i);
  end
  assign any_free = ~&valid;
endmodule

// File: rtl/entry_table_ctrl.sv
// entry_table_ctrl: allocation, write-enable and read-handshake control for the wired-OR entry table
module entry_table_ctrl
  import entry_table_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alloc_req,
  input  logic [B_W-1:0]         alloc_b,
  output logic                   alloc_gnt,
  output logic [IDX_W-1:0]       alloc_idx,
  input  logic                   free_req,
  input  logic [IDX_W-1:0]       free_idx,
  input  logic                   upd_req,
  input  logic [IDX_W-1:0]       upd_idx,
  input  logic [A_W-1:0]         upd_a,
  input  logic                   rd_req,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic                   rd_rdy,
  output logic                   rd_valid,
  output logic                   rd_hit,
  output logic [A_W-1:0]         rd_a,
  output logic [B_W-1:0]         rd_b,
  output logic [A_W-1:0]         value_a,
  output logic [B_W-1:0]         value_b,
  output logic [NUM_ENTRIES-1:0] a_in_en,
  output logic [NUM_ENTRIES-1:0] b_in_en,
  output logic [NUM_ENTRIES-1:0] a_out_en,
  output logic [NUM_ENTRIES-1:0] b_out_en,
  input  logic [A_W-1:0]         a_bus,
  input  logic [B_W-1:0]         b_bus,
  output logic [IDX_W:0]         free_count,
  output logic                   full,
  output logic                   err_free
);
  localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(NUM_ENTRIES);
  logic [NUM_ENTRIES-1:0] valid;
  logic [IDX_W-1:0] low_idx, ridx;
  logic any_free, free_ok, upd_ok, rd_acc;
  rd_state_t state, state_n;
  lowest_free_enc u_enc (.valid(valid), .idx(low_idx), .any_free(any_free));
  assign full = !any_free;
  assign alloc_gnt = alloc_req && !full;
  assign alloc_idx = low_idx;
  assign free_ok = free_req && valid[free_idx];
  assign upd_ok = upd_req && valid[upd_idx];
  // a read must not sample an entry whose table write is still in flight
  assign rd_rdy = (state == IDLE) && !(|a_in_en) && !(|b_in_en);
  assign rd_acc = rd_req && rd_rdy;
  assign b_out_en = a_out_en;
  always_comb begin
    state_n = (state == IDLE) ? (rd_acc ? DRIVE : IDLE) : (state == DRIVE) ? RESP : IDLE;
    rd_valid = state == RESP;
    a_out_en = (state == DRIVE && valid[ridx]) ? onehot(ridx) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      free_count <= CNT_MAX;
      a_in_en <= '0;
      b_in_en <= '0;
      value_a <= '0;
      value_b <= '0;
      err_free <= 1'b0;
      ridx <= '0;
      rd_hit <= 1'b0;
      rd_a <= '0;
      rd_b <= '0;
    end else begin
      valid <= (valid & ~(free_ok ? onehot(free_idx) : '0)) | (alloc_gnt ? onehot(low_idx) : '0);
      free_count <= (free_ok && !alloc_gnt && free_count != CNT_MAX) ? free_count + 1'b1 :
                    (alloc_gnt && !free_ok && free_count != '0) ? free_count - 1'b1 : free_count;
      b_in_en <= alloc_gnt ? onehot(low_idx) : '0;
      if (alloc_gnt) value_b <= alloc_b;
      a_in_en <= upd_ok ? onehot(upd_idx) : '0;
      if (upd_ok) value_a <= upd_a;
      err_free <= free_req && !valid[free_idx];
      if (rd_acc) ridx <= rd_idx;
      // capture uses the pre-edge valid bit, so a concurrent free does not affect this read
      if (state == DRIVE) begin
        rd_hit <= valid[ridx];
        rd_a <= valid[ridx] ? a_bus : '0;
        rd_b <= valid[ridx] ? b_bus : '0;
      end
    end
  end
endmodule

// File: tb/tb_entry_table_ctrl.sv
// tb_entry_table_ctrl: directed plus random stimulus against a behavioural model of the controller and table
module tb_entry_table_ctrl;
  logic clk = 0, reset = 1;
  logic alloc_req = 0, free_req = 0, upd_req = 0, rd_req = 0;
  logic [15:0] alloc_b = 0;
  logic [4:0] free_idx = 0, upd_idx = 0, upd_a = 0, rd_idx = 0;
  logic alloc_gnt, rd_rdy, rd_valid, rd_hit, full, err_free;
  logic [4:0] alloc_idx, rd_a, value_a, a_bus;
  logic [15:0] rd_b, value_b, b_bus;
  logic [31:0] a_in_en, b_in_en, a_out_en, b_out_en;
  logic [5:0] free_count;
  logic [4:0] tab_a [32] = '{default: '0};
  logic [15:0] tab_b [32] = '{default: '0};
  int errors = 0, checks = 0;
  bit used [32];
  int nfree, pb_idx, pa_idx, rphase, ridx;
  logic [15:0] pb_val, mb [32];
  logic [4:0] pa_val, ma [32];
  bit perr, ehit;
  logic [4:0] ea;
  logic [15:0] eb;

  entry_table_ctrl dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_b(alloc_b), .alloc_gnt(alloc_gnt),
    .alloc_idx(alloc_idx), .free_req(free_req), .free_idx(free_idx), .upd_req(upd_req),
    .upd_idx(upd_idx), .upd_a(upd_a), .rd_req(rd_req), .rd_idx(rd_idx), .rd_rdy(rd_rdy),
    .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_a(rd_a), .rd_b(rd_b), .value_a(value_a),
    .value_b(value_b), .a_in_en(a_in_en), .b_in_en(b_in_en), .a_out_en(a_out_en),
    .b_out_en(b_out_en), .a_bus(a_bus), .b_bus(b_bus), .free_count(free_count), .full(full),
    .err_free(err_free)
  );

  always #5 clk = ~clk;

  // the wired-OR table itself: latches on its in-enables, ORs every enabled entry onto the buses
  always @(posedge clk)
    for (int i = 0; i < 32; i++) begin
      if (a_in_en[i]) tab_a[i] <= value_a;
      if (b_in_en[i]) tab_b[i] <= value_b;
    end
  always_comb begin
    a_bus = '0;
    b_bus = '0;
    for (int i = 0; i < 32; i++) begin
      if (a_out_en[i]) a_bus = a_bus | tab_a[i];
      if (b_out_en[i]) b_bus = b_bus | tab_b[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lowest();
    for (int i = 0; i < 32; i++) if (!used[i]) return i;
    return 0;
  endfunction

  function automatic logic [4:0] pick_used();
    int s = $urandom_range(31);
    for (int i = 0; i < 32; i++) if (used[(s + i) % 32]) return 5'((s + i) % 32);
    return 5'(s);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) used[i] = 0;
    nfree = 32; pb_idx = -1; pa_idx = -1; perr = 0; rphase = 0; ridx = 0;
    ehit = 0; ea = 0; eb = 0;
  endtask

  task automatic set_idle();
    alloc_req = 0; free_req = 0; upd_req = 0; rd_req = 0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 0;
    model_reset();
  endtask

  // checks every output against the model for the current cycle, then advances one clock
  task automatic cycle();
    int low;
    bit gnt, rdy, fok;
    logic [31:0] oe;
    #1;
    low = lowest();
    gnt = alloc_req && nfree > 0;
    rdy = rphase == 0 && pb_idx < 0 && pa_idx < 0;
    oe = (rphase == 1 && used[ridx]) ? 32'd1 << ridx : 32'd0;
    chk("full", 32'(full), 32'(nfree == 0));
    chk("free_count", 32'(free_count), nfree);
    chk("alloc_gnt", 32'(alloc_gnt), 32'(gnt));
    if (gnt) chk("alloc_idx", 32'(alloc_idx), low);
    chk("b_in_en", b_in_en, pb_idx >= 0 ? 32'd1 << pb_idx : 32'd0);
    if (pb_idx >= 0) chk("value_b", 32'(value_b), 32'(pb_val));
    chk("a_in_en", a_in_en, pa_idx >= 0 ? 32'd1 << pa_idx : 32'd0);
    if (pa_idx >= 0) chk("value_a", 32'(value_a), 32'(pa_val));
    chk("err_free", 32'(err_free), 32'(perr));
    chk("rd_rdy", 32'(rd_rdy), 32'(rdy));
    chk("a_out_en", a_out_en, oe);
    chk("b_out_en", b_out_en, oe);
    chk("rd_valid", 32'(rd_valid), 32'(rphase == 2));
    if (rphase == 2) begin
      chk("rd_hit", 32'(rd_hit), 32'(ehit));
      chk("rd_a", 32'(rd_a), 32'(ea));
      chk("rd_b", 32'(rd_b), 32'(eb));
    end
    @(posedge clk);
    if (rphase == 1) begin
      ehit = used[ridx];
      ea = ehit ? ma[ridx] : 5'd0;
      eb = ehit ? mb[ridx] : 16'd0;
    end
    if (pb_idx >= 0) mb[pb_idx] = pb_val;
    if (pa_idx >= 0) ma[pa_idx] = pa_val;
    fok = free_req && used[free_idx];
    perr = free_req && !used[free_idx];
    pa_idx = (upd_req && used[upd_idx]) ? int'(upd_idx) : -1;
    pa_val = upd_a;
    pb_idx = gnt ? low : -1;
    pb_val = alloc_b;
    if (fok) used[free_idx] = 0;
    if (gnt) used[low] = 1;
    nfree = nfree + int'(fok) - int'(gnt);
    if (rphase == 0 && rd_req && rdy) begin
      rphase = 1;
      ridx = rd_idx;
    end else rphase = rphase == 1 ? 2 : 0;
    #2;
  endtask

  task automatic read_wait(input logic [4:0] idx);
    rd_req = 1;
    rd_idx = idx;
    for (int n = 0; n < 8 && rphase == 0; n++) cycle();
    if (rphase == 0) begin
      checks++;
      errors++;
      $error("FAIL rd_accept: no acceptance within 8 cycles");
    end
    rd_req = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin ma[i] = 0; mb[i] = 0; end
    do_reset();
    #1;
    chk("rst_value_a", 32'(value_a), 0);
    chk("rst_value_b", 32'(value_b), 0);
    chk("rst_free_count", 32'(free_count), 32);
    cycle();
    for (int k = 0; k < 32; k++) begin
      alloc_req = 1;
      alloc_b = k == 0 ? 16'hBEEF : 16'($urandom);
      #1;
      chk("alloc_order", 32'(alloc_idx), k);
      if (k == 1) begin
        chk("first_b_in_en", b_in_en, 32'h1);
        chk("first_value_b", 32'(value_b), 32'hBEEF);
      end
      cycle();
    end
    #1;
    chk("full_after_32", 32'(full), 1);
    chk("gnt_when_full", 32'(alloc_gnt), 0);
    chk("count_when_full", 32'(free_count), 0);
    cycle();
    alloc_req = 0;
    read_wait(5'd0);
    cycle();
    #1;
    chk("beef_valid", 32'(rd_valid), 1);
    chk("beef_rd_b", 32'(rd_b), 32'hBEEF);
    chk("beef_hit", 32'(rd_hit), 1);
    cycle();

    do_reset();
    alloc_req = 1;
    repeat (4) cycle();
    alloc_req = 0; free_req = 1; free_idx = 2;
    cycle();
    free_req = 0; alloc_req = 1;
    #1;
    chk("realloc_idx2", 32'(alloc_idx), 2);
    cycle();
    free_req = 1; free_idx = 2;
    #1;
    chk("same_cyc_idx4", 32'(alloc_idx), 4);
    chk("count_before", 32'(free_count), 28);
    cycle();
    set_idle();
    #1;
    chk("count_after", 32'(free_count), 28);
    cycle();
    free_req = 1; free_idx = 7;
    cycle();
    free_req = 0;
    #1;
    chk("err_free_pulse", 32'(err_free), 1);
    chk("err_count", 32'(free_count), 28);
    cycle();
    cycle();

    read_wait(5'd9);
    #1;
    chk("unalloc_out_en", a_out_en, 0);
    cycle();
    #1;
    chk("unalloc_valid", 32'(rd_valid), 1);
    chk("unalloc_hit", 32'(rd_hit), 0);
    chk("unalloc_a", 32'(rd_a), 0);
    chk("unalloc_b", 32'(rd_b), 0);
    cycle();

    upd_req = 1; upd_idx = 3; upd_a = 5'd17;
    cycle();
    upd_req = 0; rd_req = 1; rd_idx = 3;
    #1;
    chk("upd_a_in_en", a_in_en, 32'h8);
    chk("upd_value_a", 32'(value_a), 17);
    chk("rd_held_off", 32'(rd_rdy), 0);
    cycle();
    #1;
    chk("rd_ready_next", 32'(rd_rdy), 1);
    cycle();
    rd_req = 0;
    cycle();
    #1;
    chk("upd_rd_a", 32'(rd_a), 17);
    cycle();

    read_wait(5'd3);
    reset = 1;
    @(posedge clk);
    #2;
    chk("midrd_valid", 32'(rd_valid), 0);
    chk("midrd_hit", 32'(rd_hit), 0);
    chk("midrd_a", 32'(rd_a), 0);
    chk("midrd_b", 32'(rd_b), 0);
    chk("midrd_out_en", a_out_en, 0);
    chk("midrd_value_a", 32'(value_a), 0);
    @(posedge clk);
    #2;
    chk("midrd_valid2", 32'(rd_valid), 0);
    reset = 0;
    model_reset();
    cycle();

    for (int n = 0; n < 400; n++) begin
      alloc_req = $urandom_range(1);
      alloc_b = 16'($urandom);
      free_req = $urandom_range(9) < 3;
      free_idx = $urandom_range(3) != 0 ? pick_used() : 5'($urandom);
      upd_req = $urandom_range(9) < 3;
      upd_idx = $urandom_range(3) != 0 ? pick_used() : 5'($urandom);
      upd_a = 5'($urandom);
      rd_req = $urandom_range(9) < 4;
      rd_idx = $urandom_range(3) != 0 ? pick_used() : 5'($urandom);
      cycle();
    end
    set_idle();
    repeat (3) cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/entry_table_ctrl.md
Name: entry_table_ctrl

Overview:
- Control stage directly upstream of the wired-OR entry table (32 entries of a 5-bit A field and a 16-bit B field).
- Tracks which entries are in use and allocates the lowest free index.
- Drives the table's one-hot per-entry enables and shared write data.
- Runs a read handshake that asserts one entry's output enable, samples the wired-OR buses and returns the result.

Parameters:
- NUM_ENTRIES, 32, number of table entries.
- IDX_W, 5, index width; 2**IDX_W == NUM_ENTRIES.
- A_W, 5, width of the A field.
- B_W, 16, width of the B field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- alloc_req  in  1  request to allocate a free entry.
- alloc_b  in  B_W  initial B value for the allocated entry.
- alloc_gnt  out  1  allocation granted this cycle (combinational).
- alloc_idx  out  IDX_W  granted index: lowest free entry (combinational).
- free_req  in  1  release an entry.
- free_idx  in  IDX_W  index to release.
- upd_req  in  1  overwrite the A field of an entry.
- upd_idx  in  IDX_W  entry to update.
- upd_a  in  A_W  new A value.
- rd_req  in  1  read request.
- rd_idx  in  IDX_W  entry to read.
- rd_rdy  out  1  controller can accept a read request.
- rd_valid  out  1  one-cycle pulse: rd_a, rd_b and rd_hit are valid.
- rd_hit  out  1  the entry read was allocated.
- rd_a  out  A_W  captured A value.
- rd_b  out  B_W  captured B value.
- value_a  out  A_W  shared A write data to the table.
- value_b  out  B_W  shared B write data to the table.
- a_in_en  out  NUM_ENTRIES  one-hot A write enable.
- b_in_en  out  NUM_ENTRIES  one-hot B write enable.
- a_out_en  out  NUM_ENTRIES  one-hot A output enable.
- b_out_en  out  NUM_ENTRIES  one-hot B output enable.
- a_bus  in  A_W  wired-OR A output of the table.
- b_bus  in  B_W  wired-OR B output of the table.
- free_count  out  IDX_W+1  number of free entries.
- full  out  1  no free entry (free_count == 0).
- err_free  out  1  one-cycle pulse: free_req targeted an unallocated entry.

Behaviour:
- Reset:
  - valid vector cleared; free_count = NUM_ENTRIES.
  - All enables, value_a, value_b, rd_* and err_free are 0; FSM in IDLE.
  - Reset mid-read abandons the transaction; no rd_valid is produced.
- Allocation:
  - alloc_gnt = alloc_req && !full.
  - alloc_idx = lowest index whose valid bit is 0 in the current (pre-edge) vector.
  - On grant: valid[alloc_idx] is set at the edge.
  - Next cycle: b_in_en = one-hot(alloc_idx) and value_b = alloc_b, both registered, for exactly one cycle. The table latches at the end of that cycle (2 edges after grant).
- Free:
  - If valid[free_idx] = 1, the bit is cleared at the edge.
  - Otherwise ignored; err_free pulses the next cycle.
  - A freed entry is not grantable in the same cycle.
  - Alloc and free in the same cycle: free_count is unchanged.
- Update:
  - If valid[upd_idx] = 1: next cycle a_in_en = one-hot(upd_idx) and value_a = upd_a for one cycle.
  - Otherwise ignored.
- Enable rules:
  - a_in_en and b_in_en are each one-hot or all-zero.
  - a_out_en and b_out_en are identical and one-hot or all-zero. Never two drivers on the wired-OR buses.
- Read FSM:
  - IDLE → DRIVE → RESP → IDLE.
  - rd_rdy = (state == IDLE) && no table write enable asserted this cycle. This prevents reading stale data under a pending write.
  - rd_req && rd_rdy latches rd_idx and moves to DRIVE.
  - DRIVE: a_out_en/b_out_en = one-hot(idx) if valid[idx], else all-zero. At the end of DRIVE, a_bus, b_bus and valid[idx] are captured.
  - RESP: rd_valid = 1 for one cycle; rd_a, rd_b and rd_hit hold their values until the next capture.
  - A read of an unallocated entry returns rd_hit = 0, rd_a = 0, rd_b = 0.
  - Latency from the accepting edge to rd_valid: 2 cycles. Throughput: one read per 3 cycles.
- A free of the entry being read while in DRIVE takes effect after capture; rd_hit reflects the pre-free state.
- free_count is saturating-safe: it never exceeds NUM_ENTRIES and never goes below 0.

Decomposition:
- Package entry_table_pkg: NUM_ENTRIES, IDX_W, A_W, B_W constants; read FSM state enum (IDLE, DRIVE, RESP); one-hot decode function.
- One sub-module, lowest_free_enc: combinational priority encoder over the inverted valid vector, producing index plus any-free flag.

Test Plan:
- Reset, then 32 back-to-back allocs → alloc_idx 0..31 in order; full = 1 after the 32nd; a 33rd alloc_req gives alloc_gnt = 0; free_count = 0.
- Alloc with alloc_b = 16'hBEEF granted at idx 0 → b_in_en = 32'h1 and value_b = 16'hBEEF one cycle later; a read of idx 0 afterwards returns rd_b = 16'hBEEF, rd_hit = 1, rd_valid 2 cycles after acceptance.
- Allocate idx 0..3, free idx 2, then alloc → granted idx 2. Free idx 2 and alloc in the same cycle with idx 4 lowest free → grant idx 4, free_count unchanged.
- free_req idx 7 when unallocated → err_free pulse, valid vector and free_count unchanged.
- Read idx 9 when unallocated → a_out_en = 0 during DRIVE, rd_hit = 0, rd_a = 0, rd_b = 0. Assert reset during DRIVE → no rd_valid, all outputs 0.
- upd_req idx 3 with upd_a = 5'd17 → a_in_en = 32'h8 and value_a = 17 next cycle. rd_req asserted in that same cycle is held off (rd_rdy = 0) and accepted on the following cycle.
